// File: rtl/morse_pkg.sv
// Shared types, unit constants and the ASCII-to-Morse encoder for the
// buffered Morse transmitter.
package morse_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MARK,
        ST_SPACE,
        ST_LGAP,
        ST_WGAP
    } morse_state_e;

    // Durations in Morse units.
    localparam int unsigned MARK_DOT       = 1;
    localparam int unsigned MARK_DASH      = 3;
    localparam int unsigned GAP_SYM        = 1;
    localparam int unsigned GAP_LET        = 3;
    localparam int unsigned GAP_WORD_EXTRA = 4;

    // Symbols are sent MSB-first starting at pattern[len-1]; a 1 bit is a dash.
    typedef struct packed {
        logic       valid;
        logic       is_space;
        logic [2:0] len;
        logic [4:0] pattern;
    } morse_code_t;

    function automatic morse_code_t sym(input logic [2:0] l, input logic [4:0] p);
        morse_code_t c;
        c.valid    = 1'b1;
        c.is_space = 1'b0;
        c.len      = l;
        c.pattern  = p;
        return c;
    endfunction

    // Lowercase folds onto uppercase; anything not covered returns valid=0.
    function automatic morse_code_t morse_encode(input logic [6:0] ascii);
        morse_code_t c;
        logic [6:0]  up;
        c  = '0;
        up = ascii;
        if (ascii >= 7'd97 && ascii <= 7'd122) begin
            up = ascii - 7'd32;
        end
        case (up)
            7'd32: begin c.valid = 1'b1; c.is_space = 1'b1; end
            7'd48: c = sym(3'd5, 5'b11111);  // 0
            7'd49: c = sym(3'd5, 5'b01111);  // 1
            7'd50: c = sym(3'd5, 5'b00111);  // 2
            7'd51: c = sym(3'd5, 5'b00011);  // 3
            7'd52: c = sym(3'd5, 5'b00001);  // 4
            7'd53: c = sym(3'd5, 5'b00000);  // 5
            7'd54: c = sym(3'd5, 5'b10000);  // 6
            7'd55: c = sym(3'd5, 5'b11000);  // 7
            7'd56: c = sym(3'd5, 5'b11100);  // 8
            7'd57: c = sym(3'd5, 5'b11110);  // 9
            7'd65: c = sym(3'd2, 5'b00001);  // A .-
            7'd66: c = sym(3'd4, 5'b01000);  // B -...
            7'd67: c = sym(3'd4, 5'b01010);  // C -.-.
            7'd68: c = sym(3'd3, 5'b00100);  // D -..
            7'd69: c = sym(3'd1, 5'b00000);  // E .
            7'd70: c = sym(3'd4, 5'b00010);  // F ..-.
            7'd71: c = sym(3'd3, 5'b00110);  // G --.
            7'd72: c = sym(3'd4, 5'b00000);  // H ....
            7'd73: c = sym(3'd2, 5'b00000);  // I ..
            7'd74: c = sym(3'd4, 5'b00111);  // J .---
            7'd75: c = sym(3'd3, 5'b00101);  // K -.-
            7'd76: c = sym(3'd4, 5'b00100);  // L .-..
            7'd77: c = sym(3'd2, 5'b00011);  // M --
            7'd78: c = sym(3'd2, 5'b00010);  // N -.
            7'd79: c = sym(3'd3, 5'b00111);  // O ---
            7'd80: c = sym(3'd4, 5'b00110);  // P .--.
            7'd81: c = sym(3'd4, 5'b01101);  // Q --.-
            7'd82: c = sym(3'd3, 5'b00010);  // R .-.
            7'd83: c = sym(3'd3, 5'b00000);  // S ...
            7'd84: c = sym(3'd1, 5'b00001);  // T -
            7'd85: c = sym(3'd3, 5'b00001);  // U ..-
            7'd86: c = sym(3'd4, 5'b00001);  // V ...-
            7'd87: c = sym(3'd3, 5'b00011);  // W .--
            7'd88: c = sym(3'd4, 5'b01001);  // X -..-
            7'd89: c = sym(3'd4, 5'b01011);  // Y -.--
            7'd90: c = sym(3'd4, 5'b01100);  // Z --..
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/morse_tx_fifo_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is always visible on pop_data.
// Flush empties it and suppresses any push or pop in the same cycle.
module sync_fifo #(
    parameter int DATA_W     = 7,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full     = (count_q == DEPTH_CNT);
    assign empty    = (count_q == '0);
    assign do_push  = push && !full && !flush;
    assign do_pop   = pop && !empty && !flush;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointer/count next state; power-of-two depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + (PTR_W + 1)'(1);
            else if (do_pop && !do_push) count_d = count_q - (PTR_W + 1)'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/morse_tx_fifo.sv
// Buffered Morse transmitter: characters are queued in a FIFO, encoded on
// pop and keyed onto Y with unit timing of DOT_CYCLES clocks.
module morse_tx_fifo
    import morse_pkg::*;
#(
    parameter int DOT_CYCLES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RxData,
    input  logic              RxValid,
    output logic              RxReady,
    input  logic              Flush,
    output logic              Y,
    output logic              Busy,
    output logic              Err
);

    localparam int CNT_W = $clog2(7 * DOT_CYCLES) > 0 ? $clog2(7 * DOT_CYCLES) : 1;

    function automatic logic [CNT_W-1:0] units(input int unsigned n);
        return CNT_W'(n * DOT_CYCLES - 1);
    endfunction

    morse_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        pattern_q, pattern_d;
    logic [2:0]        idx_q, idx_d;
    logic              err_q, err_d;

    logic              fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic [6:0]        ch7;
    logic              ch_ok;
    morse_code_t       code;
    logic [2:0]        first_idx;
    logic              unit_done;
    logic              load_next;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (RST),
        .flush     (Flush),
        .push      (RxValid),
        .push_data (RxData),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Characters wider than 7 bits are only supported when the upper bits are zero.
    generate
        if (DATA_W > 7) begin : g_wide
            assign ch7   = fifo_dout[6:0];
            assign ch_ok = ~|fifo_dout[DATA_W-1:7];
        end else begin : g_narrow
            assign ch7   = 7'(fifo_dout);
            assign ch_ok = 1'b1;
        end
    endgenerate

    assign code      = morse_encode(ch7);
    assign first_idx = code.len - 3'd1;
    assign unit_done = (cnt_q == '0);

    assign RxReady = !fifo_full;
    assign Y       = (state_q == ST_MARK);
    assign Busy    = (state_q != ST_IDLE) || !fifo_empty;
    assign Err     = err_q;

    // Next-state logic. A finishing letter/word gap pops the next character on
    // the same edge, so queued characters are spaced by exactly the gap units.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pattern_d = pattern_q;
        idx_d     = idx_q;
        err_d     = 1'b0;
        fifo_pop  = 1'b0;
        load_next = 1'b0;

        case (state_q)
            ST_IDLE: load_next = 1'b1;
            ST_MARK: begin
                if (!unit_done) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (idx_q != 3'd0) begin
                    state_d = ST_SPACE;
                    cnt_d   = units(GAP_SYM);
                    idx_d   = idx_q - 3'd1;
                end else begin
                    state_d = ST_LGAP;
                    cnt_d   = units(GAP_LET);
                end
            end
            ST_SPACE: begin
                if (!unit_done) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = ST_MARK;
                    cnt_d   = pattern_q[idx_q] ? units(MARK_DASH) : units(MARK_DOT);
                end
            end
            ST_LGAP, ST_WGAP: begin
                if (!unit_done) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d   = ST_IDLE;
                    load_next = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_next && !fifo_empty) begin
            fifo_pop = 1'b1;
            if (!(code.valid && ch_ok)) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else if (code.is_space) begin
                state_d = ST_WGAP;
                cnt_d   = units(GAP_WORD_EXTRA);
            end else begin
                state_d   = ST_MARK;
                pattern_d = code.pattern;
                idx_d     = first_idx;
                cnt_d     = code.pattern[first_idx] ? units(MARK_DASH) : units(MARK_DOT);
            end
        end

        if (Flush) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            err_d    = 1'b0;
            fifo_pop = 1'b0;
        end
    end

    // FSM, unit counter and current-character registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pattern_q <= '0;
            idx_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pattern_q <= pattern_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_morse_tx_fifo.sv
// Directed bench for morse_tx_fifo with DOT_CYCLES=2, FIFO_DEPTH=4.
module tb_morse_tx_fifo;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [6:0] RxData = '0;
    logic       RxValid = 1'b0;
    logic       RxReady;
    logic       Flush = 1'b0;
    logic       Y;
    logic       Busy;
    logic       Err;

    int total = 0;
    int bad   = 0;

    logic ybuf [0:255];
    logic bbuf [0:255];
    logic ebuf [0:255];
    logic rbuf [0:255];

    morse_tx_fifo #(
        .DOT_CYCLES (2),
        .FIFO_DEPTH (4),
        .DATA_W     (7)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .RxData  (RxData),
        .RxValid (RxValid),
        .RxReady (RxReady),
        .Flush   (Flush),
        .Y       (Y),
        .Busy    (Busy),
        .Err     (Err)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // Index of first cycle where a captured trace differs from exp, or -1.
    function automatic int first_diff(input string exp, input int which);
        logic v;
        for (int i = 0; i < exp.len(); i++) begin
            v = (which == 0) ? ybuf[i] : (which == 1) ? bbuf[i] : (which == 2) ? ebuf[i] : rbuf[i];
            if (v !== (exp[i] == 8'h31)) return i;
        end
        return -1;
    endfunction

    function automatic logic trace_at(input int which, input int i);
        return (which == 0) ? ybuf[i] : (which == 1) ? bbuf[i] : (which == 2) ? ebuf[i] : rbuf[i];
    endfunction

    // Present one character and return right after the edge that accepts it.
    task automatic push_char(input logic [6:0] c);
        bit ok;
        ok = 1'b0;
        @(negedge CLK);
        RxData  = c;
        RxValid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (RxReady) begin
                @(posedge CLK);
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL push_accept: char=%0d actual=not_accepted required=accepted", c);
        end
    endtask

    task automatic release_inputs();
        @(negedge CLK);
        RxValid = 1'b0;
    endtask

    // Record outputs at n consecutive falling edges, starting at the current one.
    task automatic sample_run(input int n);
        for (int i = 0; i < n; i++) begin
            ybuf[i] = Y;
            bbuf[i] = Busy;
            ebuf[i] = Err;
            rbuf[i] = RxReady;
            @(negedge CLK);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (Busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL wait_idle: actual=busy required=idle within 300 cycles");
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        total++; if (Y !== 1'b0)       begin bad++; $display("FAIL reset_y: actual=%b required=0", Y); end
        total++; if (Err !== 1'b0)     begin bad++; $display("FAIL reset_err: actual=%b required=0", Err); end
        total++; if (Busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: actual=%b required=0", Busy); end
        total++; if (RxReady !== 1'b1) begin bad++; $display("FAIL reset_rxready: actual=%b required=1", RxReady); end
        RST = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_letter_e();
        string exp_y, exp_b, exp_e;
        int d;
        wait_idle();
        push_char(7'd69);
        release_inputs();
        sample_run(12);
        exp_y = "011000000000";
        exp_b = "111111111000";
        exp_e = "000000000000";
        d = first_diff(exp_y, 0);
        total++; if (d >= 0) begin bad++; $display("FAIL e_y_wave: cycle %0d actual=%b required=%s", d, trace_at(0, d), exp_y); end
        d = first_diff(exp_b, 1);
        total++; if (d >= 0) begin bad++; $display("FAIL e_busy_wave: cycle %0d actual=%b required=%s", d, trace_at(1, d), exp_b); end
        d = first_diff(exp_e, 2);
        total++; if (d >= 0) begin bad++; $display("FAIL e_err_wave: cycle %0d actual=%b required=%s", d, trace_at(2, d), exp_e); end
        $display("txn E: checked 12 cycles");
    endtask

    task automatic test_letter_a();
        string exp_y, exp_b;
        int d;
        exp_y = {"0", "11", "00", "111111", "000000", "00"};
        exp_b = {"11111111111111111", "00"};
        wait_idle();
        push_char(7'd65);
        release_inputs();
        sample_run(19);
        d = first_diff(exp_y, 0);
        total++; if (d >= 0) begin bad++; $display("FAIL a_upper_y_wave: cycle %0d actual=%b required=%s", d, trace_at(0, d), exp_y); end
        d = first_diff(exp_b, 1);
        total++; if (d >= 0) begin bad++; $display("FAIL a_upper_busy_wave: cycle %0d actual=%b required=%s", d, trace_at(1, d), exp_b); end
        $display("txn A: checked 19 cycles");
        wait_idle();
        push_char(7'd97);
        release_inputs();
        sample_run(19);
        d = first_diff(exp_y, 0);
        total++; if (d >= 0) begin bad++; $display("FAIL a_lower_y_wave: cycle %0d actual=%b required=%s", d, trace_at(0, d), exp_y); end
        $display("txn a: checked 19 cycles");
    endtask

    task automatic test_digit_space();
        string exp_y, exp_e;
        int d;
        exp_y = {"11111", "00", "111111", "00", "11", "00", "11", "00", "11",
                 "00000000000000", "11", "00000000"};
        exp_e = {"0000000000000000000000000", "000000000000000000000000"};
        wait_idle();
        push_char(7'd55);
        push_char(7'd32);
        push_char(7'd69);
        release_inputs();
        sample_run(49);
        d = first_diff(exp_y, 0);
        total++; if (d >= 0) begin bad++; $display("FAIL digit_space_y_wave: cycle %0d actual=%b required=%s", d, trace_at(0, d), exp_y); end
        d = first_diff(exp_e, 2);
        total++; if (d >= 0) begin bad++; $display("FAIL digit_space_err: cycle %0d actual=%b required=0", d, trace_at(2, d)); end
        $display("txn 7-space-E: checked 49 cycles");
    endtask

    task automatic test_fifo_full();
        logic [6:0] ch [6];
        string exp_y, exp_r;
        int idx, n, d;
        ch[0] = 7'd69; ch[1] = 7'd84; ch[2] = 7'd73;
        ch[3] = 7'd77; ch[4] = 7'd83; ch[5] = 7'd79;
        exp_y = {"00", "11000000", "111111000000", "110011000000",
                 "11111100111111000000", "1100110011000000"};
        exp_r = "11111000001";
        wait_idle();
        idx = 0;
        n = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge CLK);
            ybuf[n] = Y;
            rbuf[n] = RxReady;
            n++;
            RxValid = 1'b1;
            RxData  = ch[(idx < 6) ? idx : 5];
            if (rbuf[n-1] && idx < 6) begin
                @(posedge CLK);
                idx++;
            end else begin
                @(posedge CLK);
            end
        end
        @(negedge CLK);
        RxValid = 1'b0;
        while (n < 70) begin
            ybuf[n] = Y;
            rbuf[n] = RxReady;
            n++;
            @(negedge CLK);
        end
        total++; if (idx !== 5) begin bad++; $display("FAIL full_accept_count: actual=%0d required=5", idx); end
        d = first_diff(exp_r, 3);
        total++; if (d >= 0) begin bad++; $display("FAIL full_rxready: cycle %0d actual=%b required=%s", d, trace_at(3, d), exp_r); end
        d = first_diff(exp_y, 0);
        total++; if (d >= 0) begin bad++; $display("FAIL full_order_y_wave: cycle %0d actual=%b required=%s", d, trace_at(0, d), exp_y); end
        $display("txn fifo-full ETIMS: accepted=%0d checked 70 cycles", idx);
    endtask

    task automatic test_unsupported();
        string exp_y, exp_e, exp_b;
        int d;
        exp_y = "01111110000000";
        exp_e = "10000000000000";
        exp_b = "11111111111110";
        wait_idle();
        push_char(7'd35);
        push_char(7'd84);
        release_inputs();
        sample_run(14);
        d = first_diff(exp_e, 2);
        total++; if (d >= 0) begin bad++; $display("FAIL unsup_err_pulse: cycle %0d actual=%b required=%s", d, trace_at(2, d), exp_e); end
        d = first_diff(exp_y, 0);
        total++; if (d >= 0) begin bad++; $display("FAIL unsup_y_wave: cycle %0d actual=%b required=%s", d, trace_at(0, d), exp_y); end
        d = first_diff(exp_b, 1);
        total++; if (d >= 0) begin bad++; $display("FAIL unsup_busy_wave: cycle %0d actual=%b required=%s", d, trace_at(1, d), exp_b); end
        $display("txn #-T: checked 14 cycles");
    endtask

    task automatic test_flush();
        wait_idle();
        push_char(7'd83);
        push_char(7'd79);
        push_char(7'd83);
        release_inputs();
        // Now one cycle into the first S dot; the O dash begins 15 cycles later.
        repeat (16) @(negedge CLK);
        total++; if (Y !== 1'b1) begin bad++; $display("FAIL flush_pre_dash: actual=%b required=1", Y); end
        Flush   = 1'b1;
        RxValid = 1'b1;
        RxData  = 7'd69;
        @(negedge CLK);
        Flush   = 1'b0;
        RxValid = 1'b0;
        total++; if (Y !== 1'b0)       begin bad++; $display("FAIL flush_y: actual=%b required=0", Y); end
        total++; if (Busy !== 1'b0)    begin bad++; $display("FAIL flush_busy: actual=%b required=0", Busy); end
        total++; if (RxReady !== 1'b1) begin bad++; $display("FAIL flush_rxready: actual=%b required=1", RxReady); end
        repeat (4) @(negedge CLK);
        total++; if (Y !== 1'b0 || Busy !== 1'b0) begin bad++; $display("FAIL flush_push_dropped: actual=y%b/busy%b required=y0/busy0", Y, Busy); end
        $display("txn SOS flush: checked");
    endtask

    task automatic test_reset_mid();
        wait_idle();
        push_char(7'd84);
        push_char(7'd77);
        release_inputs();
        total++; if (Y !== 1'b1) begin bad++; $display("FAIL rst_pre_dash: actual=%b required=1", Y); end
        #2;
        RST = 1'b0;
        #1;
        total++; if (Y !== 1'b0)       begin bad++; $display("FAIL rst_async_y: actual=%b required=0", Y); end
        total++; if (Busy !== 1'b0)    begin bad++; $display("FAIL rst_async_busy: actual=%b required=0", Busy); end
        total++; if (RxReady !== 1'b1) begin bad++; $display("FAIL rst_async_rxready: actual=%b required=1", RxReady); end
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        repeat (3) @(negedge CLK);
        total++; if (Busy !== 1'b0 || Y !== 1'b0) begin bad++; $display("FAIL rst_fifo_empty: actual=y%b/busy%b required=y0/busy0", Y, Busy); end
        $display("txn T-M reset mid-dash: checked");
    endtask

    initial begin
        test_reset();
        test_letter_e();
        test_letter_a();
        test_digit_space();
        test_fifo_full();
        test_unsupported();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_tx_fifo.md
Name: morse_tx_fifo

Overview:
- Parametrised successor to the single-character Morse transmitter.
- Accepts 7-bit ASCII characters over a valid/ready handshake into an internal FIFO, encodes them, and drives an on/off keying line Y.
- Timing is set by a configurable dot length; supports letters, digits, space (word gap), lowercase folding, error flagging and synchronous flush.
- Sits between the character source (UART receiver / test stimulus) and the output driver (LED/buzzer).

Parameters:
- DOT_CYCLES, 4, clock cycles per Morse unit; must be >= 1.
- FIFO_DEPTH, 4, character buffer entries; must be a power of two, >= 2.
- DATA_W, 7, character width (ASCII).

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- RxData  input  DATA_W  ASCII character to transmit.
- RxValid  input  1  RxData is valid this cycle.
- RxReady  output  1  FIFO can accept; a character is accepted on an edge where RxValid && RxReady.
- Flush  input  1  synchronous; clears the FIFO and aborts the current character.
- Y  output  1  Morse keying output; 1 = tone/mark.
- Busy  output  1  high while the FSM is not in IDLE or the FIFO is non-empty.
- Err  output  1  one-cycle pulse when an unsupported character is popped.

Behaviour:
- Reset (RST=0, asynchronous):
  - Y=0, Err=0, Busy=0, RxReady=1.
  - FIFO empty, FSM in IDLE, counters cleared.
  - Holds while RST=0. Reset mid-character drops Y to 0 immediately, with no completion of the character.
- Unit: one unit = DOT_CYCLES clock cycles.
  - Dot = 1 unit Y=1; dash = 3 units Y=1.
  - Intra-character gap = 1 unit Y=0; inter-letter gap = 3 units Y=0 after every letter/digit.
  - Space (32) = 4 extra units Y=0, so letter + space = 7-unit word gap.
- Encoding:
  - 'A'-'Z' (65-90) use the ITU table.
  - 'a'-'z' (97-122) fold to uppercase.
  - '0'-'9' (48-57) are 5-symbol ITU codes.
  - All other codes are unsupported.
- FIFO:
  - RxReady = !full.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, MARK, SPACE, LGAP, WGAP.
  - IDLE: if FIFO non-empty, pop head and load code register {len[2:0], pattern[4:0]}. Symbols are sent MSB-first from bit len-1; 1 = dash.
    - Letter/digit: go to MARK.
    - Space: go to WGAP.
    - Unsupported: Err=1 for one cycle, stay IDLE; the next char may pop the following cycle, with no gap emitted.
  - MARK: Y=1 for 1 or 3 units. Then go to SPACE if symbols remain, else LGAP.
  - SPACE: Y=0 for 1 unit, then back to MARK with the next symbol.
  - LGAP: Y=0 for 3 units, then IDLE.
  - WGAP: Y=0 for 4 units, then IDLE.
- Latency:
  - Char accepted at edge k into an empty FIFO with FSM idle.
  - Pop and MARK entry at edge k+1, so Y=1 from the cycle after edge k+1.
  - Y is decoded from the registered state only, so it is glitch-free.
- Unit counter:
  - Down-counter sized $clog2(7*DOT_CYCLES).
  - Loaded with n*DOT_CYCLES-1 on state entry; the state transitions when it reaches 0.
- Flush=1 at an edge:
  - FIFO emptied, FSM to IDLE, Y=0 from the next cycle.
  - Any push in the same cycle is discarded.
  - Flush has priority over pop/push.
- Busy falls in the cycle after the final LGAP/WGAP unit completes with the FIFO empty.

Decomposition:
- Package morse_pkg:
  - State enum.
  - Constants for unit counts (MARK_DOT=1, MARK_DASH=3, GAP_SYM=1, GAP_LET=3, GAP_WORD_EXTRA=4).
  - Pure function morse_encode(ascii) returning {valid, is_space, len, pattern}.
- One sub-module, sync_fifo: parametrised by DATA_W and FIFO_DEPTH, with full/empty flags and async active-low reset.

Test Plan (DOT_CYCLES=2, FIFO_DEPTH=4):
1. Push 'E' (69) -> Y high 2 cycles, low 6 cycles; Busy drops 1 cycle later; Err never pulses.
2. Push 'A' (65) -> Y: 1x2, 0x2, 1x6, 0x6 (16 cycles total); 'a' (97) gives an identical waveform.
3. Push '7' (55), then ' ' (32), then 'E' -> pattern --... ; after '7' Y low 6+8=14 cycles; then 'E' dot.
4. Hold RxValid with 6 distinct chars from an empty, idle state -> exactly 5 accepted (1 popped + 4 stored); RxReady low thereafter until the first pop completes; output order preserved.
5. Push '#' (35) then 'T' (84) -> Err high exactly 1 cycle, Y stays 0; 'T' dash starts 1 cycle after the Err pulse with no gap.
6. Queue "SOS":
   - Assert Flush during the first dash of 'O' -> Y=0 next cycle, Busy=0, RxReady=1.
   - Separately, assert RST=0 mid-dash -> Y=0 asynchronously, FIFO empty after release.
